ptr_secded_cnt: RTL and testbench

//   Parametrised fault-tolerant FIFO pointer: counter state held as an even-parity

---
 rtl/ptr_secded_pkg.sv | 48 ++++
 rtl/ptr_secded_dec.sv | 49 ++++
 rtl/ptr_secded_cnt.sv | 81 ++++++++
 tb/tb_ptr_secded_cnt.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ptr_secded_pkg.sv
// Shared SECDED helpers for the fault-tolerant pointer: parity-bit count, code width,
// and a width-generic even-parity Hamming encoder (optional overall-parity MSB).
package ptr_secded_pkg;

  localparam int MAX_W   = 64;
  localparam int MAX_PAR = 6;

  typedef logic [MAX_W-1:0] word_t;

  // Smallest p with 2**p >= ptr_w + p + 1; descending scan so the smallest match wins.
  function automatic int calc_par_bits(input int ptr_w);
    int p;
    p = 0;
    for (int i = MAX_PAR; i >= 1; i--)
      if ((1 << i) >= ptr_w + i + 1) p = i;
    return p;
  endfunction

  function automatic int calc_code_w(input int ptr_w, input int secded);
    return ptr_w + calc_par_bits(ptr_w) + secded;
  endfunction

  function automatic word_t secded_encode(input int ptr_w, input int secded, input word_t data);
    word_t c;
    int    n, d, p;
    logic  par;
    p = calc_par_bits(ptr_w);
    n = ptr_w + p;
    c = '0;
    d = 0;
    for (int pos = 1; pos < MAX_W; pos++)
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        c[pos-1] = data[d];
        d++;
      end
    for (int i = 0; i < MAX_PAR; i++)
      if (i < p) begin
        par = 1'b0;
        for (int pos = 1; pos < MAX_W; pos++)
          if (pos <= n && (pos & (1 << i)) != 0) par ^= c[pos-1];
        c[(1 << i) - 1] = par;
      end
    // Overall bit sits just above the Hamming positions; all higher bits are still zero.
    if (secded != 0) c[n] = ^c;
    return c;
  endfunction

endpackage

// File: rtl/ptr_secded_dec.sv
// Combinational Hamming/SECDED decoder: syndrome, overall check, single-bit correction
// and error classification.
module ptr_secded_dec
  import ptr_secded_pkg::*;
#(
  parameter int  PTR_W  = 10,
  parameter int  SECDED = 1,
  localparam int P      = calc_par_bits(PTR_W),
  localparam int N      = PTR_W + P,
  localparam int CODE_W = N + SECDED
) (
  input  logic [CODE_W-1:0] i_code,
  output logic [PTR_W-1:0]  o_data,
  output logic              o_sec,
  output logic              o_ded
);

  logic [P-1:0]      w_syn;
  logic              w_ovr, w_big;
  logic [CODE_W-1:0] w_fix;
  int                d;

  always_comb begin
    w_syn = '0;
    for (int pos = 1; pos <= N; pos++)
      if (i_code[pos-1]) w_syn ^= P'(pos);
    w_ovr = (SECDED != 0) ? ^i_code : 1'b0;
    // A syndrome pointing past the last position can only come from multiple flips.
    w_big = int'(w_syn) > N;
    if (SECDED != 0) begin
      o_ded = w_big || (w_syn != '0 && !w_ovr);
      o_sec = !o_ded && w_ovr;
    end else begin
      o_ded = w_big;
      o_sec = !w_big && (w_syn != '0);
    end
    w_fix = i_code;
    for (int pos = 1; pos <= N; pos++)
      if (o_sec && w_syn == P'(pos)) w_fix[pos-1] = ~i_code[pos-1];
    o_data = '0;
    d      = 0;
    for (int pos = 1; pos <= N; pos++)
      if ((pos & (pos - 1)) != 0) begin
        o_data[d] = w_fix[pos-1];
        d++;
      end
  end

endmodule

// File: rtl/ptr_secded_cnt.sv
// Fault-tolerant FIFO pointer: count kept as a SECDED codeword, decoded and scrubbed
// every cycle; uncorrectable words freeze the pointer until clr.
module ptr_secded_cnt
  import ptr_secded_pkg::*;
#(
  parameter int  PTR_W  = 10,
  parameter int  DEPTH  = 1024,
  parameter int  SECDED = 1,
  parameter int  CNT_W  = 8,
  localparam int CODE_W = calc_code_w(PTR_W, SECDED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              inject_en,
  input  logic [CODE_W-1:0] inject_mask,
  output logic [PTR_W-1:0]  ptr_o,
  output logic [CODE_W-1:0] code_o,
  output logic              wrap_o,
  output logic              sec_err_o,
  output logic              ded_err_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  logic [CODE_W-1:0] r_code, w_base, w_next, w_enc_inc, w_enc_cur;
  logic [PTR_W-1:0]  w_ptr, w_ptr_inc;
  logic              w_sec, w_ded, w_at_max, w_wrap_evt;
  logic              r_wrap, r_sec, r_ded;
  logic [CNT_W-1:0]  r_cnt;

  ptr_secded_dec #(.PTR_W(PTR_W), .SECDED(SECDED)) u_dec (
    .i_code (r_code),
    .o_data (w_ptr),
    .o_sec  (w_sec),
    .o_ded  (w_ded)
  );

  assign w_at_max  = (w_ptr == PTR_W'(DEPTH - 1));
  assign w_ptr_inc = w_at_max ? '0 : w_ptr + PTR_W'(1);
  assign w_enc_inc = CODE_W'(secded_encode(PTR_W, SECDED, MAX_W'(w_ptr_inc)));
  assign w_enc_cur = CODE_W'(secded_encode(PTR_W, SECDED, MAX_W'(w_ptr)));

  always_comb begin
    w_base = r_code;
    if (clr)        w_base = '0;
    else if (w_ded) w_base = r_code;
    else if (inc)   w_base = w_enc_inc;
    else if (w_sec) w_base = w_enc_cur;
    // Injection corrupts whatever is written, including hold and clear.
    w_next = w_base ^ (inject_en ? inject_mask : '0);
  end

  assign w_wrap_evt = !clr && !w_ded && inc && w_at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= '0;
      r_wrap <= 1'b0;
      r_sec  <= 1'b0;
      r_ded  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_code <= w_next;
      r_wrap <= w_wrap_evt;
      r_sec  <= w_sec && !clr;
      if (clr)        r_ded <= 1'b0;
      else if (w_ded) r_ded <= 1'b1;
      if (clr)                         r_cnt <= '0;
      else if (w_sec && r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ptr_o     = w_ptr;
  assign code_o    = r_code;
  assign wrap_o    = r_wrap;
  assign sec_err_o = r_sec;
  assign ded_err_o = r_ded;
  assign err_cnt_o = r_cnt;

endmodule

// File: tb/tb_ptr_secded_cnt.sv
// Directed bench: table of per-cycle vectors for the SECDED pointer plus hand sequences
// for wrap (DEPTH=600), SEC-only mode with a saturating 2-bit counter, and async reset.
module tb_ptr_secded_cnt;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: default config
  logic        a_clr = 0, a_inc = 0, a_inj = 0;
  logic [14:0] a_mask = '0;
  logic [9:0]  a_ptr;
  logic [14:0] a_code;
  logic        a_wrap, a_sec, a_ded;
  logic [7:0]  a_cnt;

  // B: DEPTH=600
  logic        b_clr = 0, b_inc = 0, b_inj = 0;
  logic [14:0] b_mask = '0;
  logic [9:0]  b_ptr;
  logic [14:0] b_code;
  logic        b_wrap, b_sec, b_ded;
  logic [7:0]  b_cnt;

  // C: SEC only, 2-bit error counter
  logic        c_clr = 0, c_inc = 0, c_inj = 0;
  logic [13:0] c_mask = '0;
  logic [9:0]  c_ptr;
  logic [13:0] c_code;
  logic        c_wrap, c_sec, c_ded;
  logic [1:0]  c_cnt;

  ptr_secded_cnt #(.PTR_W(10), .DEPTH(1024), .SECDED(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .inc(a_inc), .inject_en(a_inj),
    .inject_mask(a_mask), .ptr_o(a_ptr), .code_o(a_code), .wrap_o(a_wrap),
    .sec_err_o(a_sec), .ded_err_o(a_ded), .err_cnt_o(a_cnt));

  ptr_secded_cnt #(.PTR_W(10), .DEPTH(600), .SECDED(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .inc(b_inc), .inject_en(b_inj),
    .inject_mask(b_mask), .ptr_o(b_ptr), .code_o(b_code), .wrap_o(b_wrap),
    .sec_err_o(b_sec), .ded_err_o(b_ded), .err_cnt_o(b_cnt));

  ptr_secded_cnt #(.PTR_W(10), .DEPTH(1024), .SECDED(0), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(c_clr), .inc(c_inc), .inject_en(c_inj),
    .inject_mask(c_mask), .ptr_o(c_ptr), .code_o(c_code), .wrap_o(c_wrap),
    .sec_err_o(c_sec), .ded_err_o(c_ded), .err_cnt_o(c_cnt));

  typedef struct {
    logic        clr, inc, inj;
    logic [14:0] mask;
    logic [9:0]  ptr;
    logic [14:0] code;
    logic        wrap, sec, ded;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic clr, inc, inj, input logic [14:0] mask,
                     input logic [9:0] ptr, input logic [14:0] code,
                     input logic wrap, sec, ded, input logic [7:0] cnt);
    vec_t v;
    v.clr = clr; v.inc = inc; v.inj = inj; v.mask = mask;
    v.ptr = ptr; v.code = code; v.wrap = wrap; v.sec = sec; v.ded = ded; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hand-computed codewords (PTR_W=10): e(0)=0000 e(1)=4007 e(2)=4019 e(3)=001E
    // e(4)=402A e(5)=002D e(6)=0033 e(7)=4034
    //   clr inc inj mask      ptr  code      wr sec ded cnt
    add(0, 1, 0, 15'h0000, 1, 15'h4007, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 2, 15'h4019, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 3, 15'h001E, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 4, 15'h402A, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 5, 15'h002D, 0, 0, 0, 0);
    add(0, 0, 1, 15'h0004, 5, 15'h0029, 0, 0, 0, 0);
    add(0, 0, 0, 15'h0000, 5, 15'h002D, 0, 1, 0, 1);
    add(0, 0, 1, 15'h4000, 5, 15'h402D, 0, 0, 0, 1);
    add(0, 0, 0, 15'h0000, 5, 15'h002D, 0, 1, 0, 2);
    add(0, 0, 1, 15'h0004, 5, 15'h0029, 0, 0, 0, 2);
    add(0, 1, 0, 15'h0000, 6, 15'h0033, 0, 1, 0, 3);
    add(0, 1, 1, 15'h0100, 7, 15'h4134, 0, 0, 0, 3);
    add(0, 0, 0, 15'h0000, 7, 15'h4034, 0, 1, 0, 4);
    add(1, 0, 0, 15'h0000, 0, 15'h0000, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 1, 15'h4007, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 2, 15'h4019, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 3, 15'h001E, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 4, 15'h402A, 0, 0, 0, 0);
    add(0, 1, 0, 15'h0000, 5, 15'h002D, 0, 0, 0, 0);
    add(0, 0, 1, 15'h0003, 5, 15'h002E, 0, 0, 0, 0);
    add(0, 0, 0, 15'h0000, 5, 15'h002E, 0, 0, 1, 0);
    add(0, 1, 0, 15'h0000, 5, 15'h002E, 0, 0, 1, 0);
    add(0, 1, 0, 15'h0000, 5, 15'h002E, 0, 0, 1, 0);
    add(0, 1, 0, 15'h0000, 5, 15'h002E, 0, 0, 1, 0);
    add(1, 0, 0, 15'h0000, 0, 15'h0000, 0, 0, 0, 0);
    add(1, 0, 1, 15'h0004, 0, 15'h0004, 0, 0, 0, 0);
    add(0, 0, 0, 15'h0000, 0, 15'h0000, 0, 1, 0, 1);
    add(0, 0, 1, 15'h0004, 0, 15'h0004, 0, 0, 0, 1);
    add(0, 0, 0, 15'h0000, 0, 15'h0000, 0, 1, 0, 2);
    add(0, 0, 1, 15'h0004, 0, 15'h0004, 0, 0, 0, 2);
    add(0, 0, 0, 15'h0000, 0, 15'h0000, 0, 1, 0, 3);
    add(0, 0, 1, 15'h0003, 0, 15'h0003, 0, 0, 0, 3);
    add(0, 0, 0, 15'h0000, 0, 15'h0003, 0, 0, 1, 3);

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst code", 32'(a_code), 32'h0);
    chk("rst ptr",  32'(a_ptr), 32'h0);
    chk("rst flags", {29'b0, a_wrap, a_sec, a_ded}, 32'h0);
    chk("rst cnt",  32'(a_cnt), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // Wrap at DEPTH=600
    b_inc = 1'b1;
    repeat (599) step();
    chk("wrap ptr599", 32'(b_ptr), 32'd599);
    chk("wrap pre", 32'(b_wrap), 32'h0);
    step();
    chk("wrap ptr0", 32'(b_ptr), 32'd0);
    chk("wrap pulse", 32'(b_wrap), 32'h1);
    chk("wrap code0", 32'(b_code), 32'h0);
    b_inc = 1'b0;
    step();
    chk("wrap one-cycle", 32'(b_wrap), 32'h0);
    b_inc = 1'b1;
    step();
    chk("wrap next ptr", 32'(b_ptr), 32'd1);
    chk("wrap next code", 32'(b_code), 32'h4007);
    b_inc = 1'b0;
    b_clr = 1'b1;
    step();
    chk("clr no wrap", {30'b0, b_wrap, (b_ptr == 10'd0)}, 32'h1);
    b_clr = 1'b0;

    // SEC-only mode, counter saturates at 3
    c_inc = 1'b1;
    repeat (5) step();
    c_inc = 1'b0;
    chk("sec-only code5", 32'(c_code), 32'h002D);
    for (int k = 1; k <= 4; k++) begin
      c_inj = 1'b1; c_mask = 14'h0004;
      step();
      c_inj = 1'b0;
      chk("sec-only corrupt", 32'(c_code), 32'h0029);
      chk("sec-only ptr", 32'(c_ptr), 32'd5);
      step();
      chk("sec-only scrub", {c_sec, 3'b0, 14'h0, c_code}, {1'b1, 3'b0, 14'h0, 14'h002D});
      chk("sec-only cnt", 32'(c_cnt), (k > 3) ? 32'd3 : 32'(k));
    end
    c_inj = 1'b1; c_mask = 14'h2001;
    step();
    c_inj = 1'b0;
    chk("sec-only s>n ptr", 32'(c_ptr), 32'd517);
    step();
    chk("sec-only s>n ded", 32'(c_ded), 32'h1);
    c_inc = 1'b1;
    step();
    c_inc = 1'b0;
    chk("sec-only frozen", 32'(c_code), 32'h202C);

    // Main table
    foreach (tbl[i]) begin
      a_clr = tbl[i].clr; a_inc = tbl[i].inc; a_inj = tbl[i].inj; a_mask = tbl[i].mask;
      step();
      chk($sformatf("row%0d ptr", i),  32'(a_ptr),  32'(tbl[i].ptr));
      chk($sformatf("row%0d code", i), 32'(a_code), 32'(tbl[i].code));
      chk($sformatf("row%0d flags", i), {29'b0, a_wrap, a_sec, a_ded},
          {29'b0, tbl[i].wrap, tbl[i].sec, tbl[i].ded});
      chk($sformatf("row%0d cnt", i),  32'(a_cnt),  32'(tbl[i].cnt));
    end
    a_clr = 1'b0; a_inc = 1'b0; a_inj = 1'b0; a_mask = '0;

    // Async reset between edges with ded set and cnt=3
    #2 rst_n = 1'b0;
    #1;
    chk("midrst code", 32'(a_code), 32'h0);
    chk("midrst ptr",  32'(a_ptr), 32'h0);
    chk("midrst flags", {29'b0, a_wrap, a_sec, a_ded}, 32'h0);
    chk("midrst cnt",  32'(a_cnt), 32'h0);
    chk("midrst c ded", 32'(c_ded), 32'h0);
    #10 rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
